// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU load/store path (master) and the memory responder (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: captures a request, waits WAIT_CYCLES, performs a
// byte/half/word access on an internal word array and returns a one-cycle response.
//
// state | meaning
// IDLE  | ready; a valid request is captured on the next edge
// BUSY  | wait-state countdown; access happens on the edge where the counter is 0
// RESP  | resp_valid high for one cycle
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);
    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept, access;

    logic        cap_write;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic             req_err;
    logic [3:0]       byte_en;
    logic [31:0]      lane_data;
    logic [IDX_W-1:0] idx;

    assign idx = cap_addr[IDX_W+1:2];

    // Legality and byte lanes are derived from the captured request, not the live bus.
    always_comb begin
        req_err   = (cap_addr >= ADDR_LIMIT);
        byte_en   = 4'b0000;
        lane_data = cap_wdata;
        case (cap_size)
            2'b00: begin
                byte_en = 4'b1111;
                if (cap_addr[1:0] != 2'b00) req_err = 1'b1;
            end
            2'b01: begin
                byte_en   = cap_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cap_wdata[15:0]}};
                if (cap_addr[0]) req_err = 1'b1;
            end
            2'b10: begin
                byte_en   = 4'b0001 << cap_addr[1:0];
                lane_data = {4{cap_wdata[7:0]}};
            end
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cap_write <= 1'b0;
            cap_size  <= 2'b00;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cap_write <= bus.req_write;
                cap_size  <= bus.req_size;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
            end
            if (access) begin
                err_q   <= req_err;
                rdata_q <= (req_err || cap_write) ? 32'd0 : mem[idx];
            end
        end
    end

    // Array is not reset; an aborted operation never reaches access, so nothing is written.
    always_ff @(posedge clk) begin
        if (access && cap_write && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
